// File: rtl/time_set_ctrl.sv
// 24-hour clock with a field-by-field set mode, driven by short/long press events.
// Long events step RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN; short events edit the blinking field.
module time_set_ctrl #(
    parameter int CLK_HZ     = 10000,
    parameter int BLINK_HALF = 2500
) (
    input  logic       clk_10000Hz,
    input  logic       rst_n,
    input  logic       inc_short,
    input  logic       inc_long,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic [1:0] mode,
    output logic       field_on,
    output logic       tick_1hz,
    output logic       day_pulse
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } mode_t;

    mode_t         mode_q;
    logic [4:0]    hour_q;
    logic [5:0]    minute_q;
    logic [5:0]    second_q;
    logic [PW-1:0] presc_q;
    logic [BW-1:0] blink_q;
    logic          field_on_q;
    logic          tick_q;
    logic          day_q;

    logic short_q, short_prev_q, short_ev_q;
    logic long_q, long_prev_q, long_ev_q;
    logic short_ev_d, long_ev_d;

    logic [4:0] hour_inc;
    logic [5:0] minute_inc;
    logic [5:0] second_inc;

    assign short_ev_d = short_q & ~short_prev_q;
    assign long_ev_d  = long_q & ~long_prev_q;

    assign hour_inc   = (hour_q == 5'd23)   ? 5'd0 : hour_q + 5'd1;
    assign minute_inc = (minute_q == 6'd59) ? 6'd0 : minute_q + 6'd1;
    assign second_inc = (second_q == 6'd59) ? 6'd0 : second_q + 6'd1;

    always_ff @(posedge clk_10000Hz or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= RUN;
            hour_q       <= '0;
            minute_q     <= '0;
            second_q     <= '0;
            presc_q      <= '0;
            blink_q      <= '0;
            field_on_q   <= 1'b1;
            tick_q       <= 1'b0;
            day_q        <= 1'b0;
            short_q      <= 1'b0;
            short_prev_q <= 1'b0;
            short_ev_q   <= 1'b0;
            long_q       <= 1'b0;
            long_prev_q  <= 1'b0;
            long_ev_q    <= 1'b0;
        end else begin
            short_q      <= inc_short;
            short_prev_q <= short_q;
            short_ev_q   <= short_ev_d;
            long_q       <= inc_long;
            long_prev_q  <= long_q;
            long_ev_q    <= long_ev_d;
            tick_q       <= 1'b0;
            day_q        <= 1'b0;

            // A long event wins over a simultaneous short one: the short is simply dropped.
            if (long_ev_q) begin
                presc_q    <= '0;
                blink_q    <= '0;
                field_on_q <= 1'b1;
                case (mode_q)
                    RUN:      mode_q <= SET_HOUR;
                    SET_HOUR: mode_q <= SET_MIN;
                    SET_MIN:  mode_q <= SET_SEC;
                    SET_SEC:  mode_q <= RUN;
                endcase
            end else if (mode_q == RUN) begin
                field_on_q <= 1'b1;
                blink_q    <= '0;
                if (presc_q == PW'(CLK_HZ - 1)) begin
                    presc_q  <= '0;
                    tick_q   <= 1'b1;
                    second_q <= second_inc;
                    if (second_q == 6'd59) begin
                        minute_q <= minute_inc;
                        if (minute_q == 6'd59) begin
                            hour_q <= hour_inc;
                            if (hour_q == 5'd23)
                                day_q <= 1'b1;
                        end
                    end
                end else begin
                    presc_q <= presc_q + PW'(1);
                end
            end else begin
                presc_q <= '0;
                if (short_ev_q) begin
                    field_on_q <= 1'b1;
                    blink_q    <= '0;
                    case (mode_q)
                        SET_HOUR: hour_q   <= hour_inc;
                        SET_MIN:  minute_q <= minute_inc;
                        default:  second_q <= second_inc;
                    endcase
                end else if (blink_q == BW'(BLINK_HALF - 1)) begin
                    blink_q    <= '0;
                    field_on_q <= ~field_on_q;
                end else begin
                    blink_q <= blink_q + BW'(1);
                end
            end
        end
    end

    assign hour      = hour_q;
    assign minute    = minute_q;
    assign second    = second_q;
    assign mode      = mode_q;
    assign field_on  = field_on_q;
    assign tick_1hz  = tick_q;
    assign day_pulse = day_q;

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Downstream consumer of the short/long press classifier. Turns its inc_short/inc_long pulses into a 24-hour clock with a field-by-field set mode.
- Keeps hours, minutes and seconds from the 10 kHz system clock.
- Drives the display path with binary time fields, the current mode, and a blink enable for the field being edited.

Parameters:
- CLK_HZ, 10000: clk_10000Hz cycles per second tick.
- BLINK_HALF, 2500: cycles per half-period of the edit-field blink (2 Hz).

Ports:
- clk_10000Hz  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- inc_short  in  1  short-press event from classifier
- inc_long  in  1  long-press event from classifier
- hour  out  5  0..23
- minute  out  6  0..59
- second  out  6  0..59
- mode  out  2  0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC
- field_on  out  1  1 = selected field visible, 0 = blanked (blink)
- tick_1hz  out  1  one-cycle pulse on every RUN-mode second advance
- day_pulse  out  1  one-cycle pulse on 23:59:59 -> 00:00:00 rollover in RUN

Behaviour:
- Interface fixed: one clock, clk_10000Hz. Reset rst_n is asynchronous, active-low.
- Reset values:
  - hour=0, minute=0, second=0, mode=RUN, field_on=1, tick_1hz=0, day_pulse=0.
  - Prescaler=0, blink counter=0.
  - Input edge registers=0.
- Event detection:
  - inc_short and inc_long are each registered. An event is a rising edge (cur=1, prev=0).
  - A level held high for N cycles counts once.
  - Events act one cycle after the edge cycle; outputs update on the following clock edge.
- Priority: long and short events in the same cycle -> only long acts; short is discarded.
- State machine, long events only:
  - RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
  - On entry to any SET state: field_on=1, blink counter=0.
- RUN:
  - Prescaler counts 0..CLK_HZ-1. At CLK_HZ-1 it wraps to 0, second increments, and tick_1hz=1 for one cycle.
  - Carry chain: second 59->0 increments minute; minute 59->0 increments hour; hour 23->0 with day_pulse=1 in the same cycle as the tick.
  - Short events ignored in RUN.
  - field_on constant 1.
- SET states:
  - Timekeeping frozen; prescaler held at 0.
  - Leaving SET_SEC to RUN restarts the prescaler at 0, so the first tick comes CLK_HZ cycles after mode returns to RUN.
  - A short event increments only the selected field, with modular wrap and no carry: hour 23->0, minute 59->0, second 59->0.
  - A short event also forces field_on=1 and clears the blink counter.
  - Blink counter counts 0..BLINK_HALF-1; at wrap, field_on toggles.
  - tick_1hz and day_pulse stay 0.
- Width rules: all increments are compare-then-wrap. Values outside the legal range can never be produced.
- Reset mid-operation (any mode, any count): immediate return to the reset values. No pending event survives reset.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
1. Reset, then run 3*CLK_HZ cycles in RUN -> second=3, exactly 3 tick_1hz pulses, first at cycle CLK_HZ after reset release.
2. Preload 23:59:58 via SET mode, return to RUN, wait 2*CLK_HZ cycles -> 00:00:00; day_pulse and tick_1hz both high in the same single cycle.
3. Long pulse -> mode=1; 25 short pulses -> hour=1 (wrap at 24); long -> mode=2; 61 shorts -> minute=1; long, long -> mode=0, second unchanged.
4. In SET_MIN with no activity for 10000 cycles -> field_on toggles every 2500 cycles (4 toggles). A short pulse at cycle 3000 -> field_on=1 the next cycle and the blink period restarts.
5. inc_short and inc_long rising together in SET_HOUR -> mode=2, hour unchanged. inc_short held high 500 cycles -> exactly one increment.
6. Assert rst_n=0 mid-SET_SEC with second=37 and blink low -> all outputs at reset values immediately, without waiting for a clock edge. Release -> RUN counting from 00:00:00.
